// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide controller.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    // Quotient reported for any divide by zero; the remainder carries the dividend.
    localparam logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generator: signed/unsigned multiply and divide,
// including the divide-by-zero and signed-overflow cases.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [63:0] result
);

    logic signed [63:0] smul_s;
    logic        [63:0] umul_s;
    logic               div_zero_s;
    logic               div_ovf_s;
    logic        [31:0] safe_rt_s;
    logic signed [31:0] squot_s;
    logic signed [31:0] srem_s;
    logic        [31:0] uquot_s;
    logic        [31:0] urem_s;

    assign smul_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign umul_s = {32'd0, rs_val} * {32'd0, rt_val};

    assign div_zero_s = (rt_val == 32'd0);
    assign div_ovf_s  = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);

    // Special cases are muxed in below, so the dividers never see a zero or overflowing divisor.
    assign safe_rt_s = (div_zero_s || div_ovf_s) ? 32'd1 : rt_val;
    assign squot_s   = $signed(rs_val) / $signed(safe_rt_s);
    assign srem_s    = $signed(rs_val) % $signed(safe_rt_s);
    assign uquot_s   = rs_val / safe_rt_s;
    assign urem_s    = rs_val % safe_rt_s;

    // Select the {hi,lo} pair for the requested operation.
    always_comb begin
        result = 64'd0;
        case (op)
            MDU_MULT:  result = $unsigned(smul_s);
            MDU_MULTU: result = umul_s;
            MDU_DIV: begin
                if (div_zero_s) begin
                    result = {rs_val, DIVZERO_LO};
                end else if (div_ovf_s) begin
                    result = {32'd0, 32'h8000_0000};
                end else begin
                    result = {$unsigned(srem_s), $unsigned(squot_s)};
                end
            end
            MDU_DIVU: begin
                if (div_zero_s) begin
                    result = {rs_val, DIVZERO_LO};
                end else begin
                    result = {urem_s, uquot_s};
                end
            end
            default:   result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO owner and latency-emulating multiply/divide controller for the EX stage.
// Define MDU_FLUSH_EN to add a flush input that squashes a pending operation.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MDU_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

    state_t      state_r, state_nxt_s;
    logic [3:0]  cnt_r, cnt_nxt_s;
    logic [31:0] pend_hi_r, pend_hi_nxt_s;
    logic [31:0] pend_lo_r, pend_lo_nxt_s;
    logic [31:0] hi_r, hi_nxt_s;
    logic [31:0] lo_r, lo_nxt_s;
    logic        busy_r, busy_nxt_s;

    logic        flush_s;
    logic        accept_s;
    logic        is_mul_s;
    logic        is_long_s;
    logic [63:0] arith_s;

`ifdef MDU_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    // Commands are only taken in IDLE; anything arriving while busy is dropped.
    assign accept_s  = (state_r == IDLE) && start && !flush_s;
    assign is_mul_s  = (mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU);
    assign is_long_s = is_mul_s || (mdu_op == MDU_DIV) || (mdu_op == MDU_DIVU);

    mdu_arith u_arith (
        .op     (mdu_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .result (arith_s)
    );

    // State, counter, pending result and architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            pend_hi_r <= pend_hi_nxt_s;
            pend_lo_r <= pend_lo_nxt_s;
            hi_r      <= hi_nxt_s;
            lo_r      <= lo_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && is_long_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (flush_s || (cnt_r == 4'd1)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath next values: load on accept, count down in RUN, commit on the last cycle.
    always_comb begin
        cnt_nxt_s     = cnt_r;
        pend_hi_nxt_s = pend_hi_r;
        pend_lo_nxt_s = pend_lo_r;
        hi_nxt_s      = hi_r;
        lo_nxt_s      = lo_r;
        busy_nxt_s    = busy_r;
        case (state_r)
            IDLE: begin
                if (accept_s && is_long_s) begin
                    cnt_nxt_s     = is_mul_s ? MUL_CNT : DIV_CNT;
                    pend_hi_nxt_s = arith_s[63:32];
                    pend_lo_nxt_s = arith_s[31:0];
                    busy_nxt_s    = 1'b1;
                end else if (accept_s && (mdu_op == MDU_MTHI)) begin
                    hi_nxt_s = rs_val;
                end else if (accept_s && (mdu_op == MDU_MTLO)) begin
                    lo_nxt_s = rs_val;
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            RUN: begin
                if (flush_s) begin
                    cnt_nxt_s     = 4'd0;
                    pend_hi_nxt_s = 32'd0;
                    pend_lo_nxt_s = 32'd0;
                    busy_nxt_s    = 1'b0;
                end else if (cnt_r == 4'd1) begin
                    cnt_nxt_s  = 4'd0;
                    hi_nxt_s   = pend_hi_r;
                    lo_nxt_s   = pend_lo_r;
                    busy_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                cnt_nxt_s  = 4'd0;
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller for the MIPS pipeline's HI/LO resource; sits beside the ALU in the EX stage.
- Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO command per idle cycle and emulates the real unit's latency with a countdown.
- Asserts busy so the hazard unit can stall MFHI/MFLO and further MDU instructions.
- Owns the architectural HI and LO registers.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command valid for one cycle, from EX stage.
- mdu_op  input  3  command: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
- rs_val  input  32  operand A (dividend / multiplicand / MTHI/MTLO source).
- rt_val  input  32  operand B (divisor / multiplier).
- busy  output  1  registered; high while an operation is pending.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

Behaviour:
- Reset: synchronous on rising clk. busy=0, hi=0, lo=0, counter=0, state=IDLE, pending result cleared. Reset mid-operation discards the pending result.
- FSM states: IDLE and RUN.
- IDLE, start=1 with MULT/MULTU/DIV/DIVU:
  - Compute the 64-bit result from the operands at that edge and hold it in pend_hi/pend_lo.
  - Load counter with MUL_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 from the next cycle.
- IDLE, start=1 with MTHI/MTLO: write rs_val into hi or lo at that edge. busy stays 0; latency 1.
- IDLE, start=1 with op 6 or 7: ignored.
- RUN: counter decrements each cycle. When counter reaches 1, commit pend_hi→hi and pend_lo→lo at that edge, clear busy, go to IDLE.
  - hi/lo change exactly N cycles after the start edge.
  - busy is high for exactly N cycles.
- start=1 while busy (any op, including MTHI/MTLO) is ignored. Preventing this is the hazard unit's job; no error flag is raised.
- start is accepted on the same cycle busy falls? No. busy is registered, so the cycle after commit is IDLE and start is accepted there. Back-to-back commands therefore need N+1 cycles each.
- Arithmetic:
  - MULT: signed 32x32→64; hi=upper 32 bits, lo=lower 32 bits.
  - MULTU: the same, unsigned.
  - DIV: lo=quotient truncated toward zero; hi=remainder, which takes the sign of the dividend.
  - DIVU: the same, unsigned.
- Divide by zero (rt_val=0), DIV or DIVU: lo=32'hFFFFFFFF, hi=rs_val. Normal latency.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- hi/lo are stable, and readable by MFHI/MFLO, whenever busy=0.

Optional Feature:
- Macro: MDU_FLUSH_EN.
- Defined:
  - Adds input flush (1 bit).
  - flush=1 in RUN discards the pending result; hi/lo keep their old values, busy=0 and state=IDLE next cycle.
  - flush=1 in IDLE blocks any start in that same cycle.
  - flush has priority over start and over the commit. Use: exception/interrupt squash.
- Not defined: no flush port; every accepted operation always commits.

Decomposition:
- Package mdu_pkg holds:
  - op encodings MDU_MULT..MDU_MTLO (3-bit localparams);
  - state encoding IDLE/RUN;
  - DIVZERO_LO constant.
- Natural sub-module: mdu_arith, a purely combinational block. Inputs: op, rs_val, rt_val. Output: 64-bit {hi,lo}. It contains the signed/unsigned multiply, the divide, and the zero/overflow special cases.
- mdu_ctrl keeps the FSM, the counter, the pending registers and the HI/LO registers.

Test Plan:
- MULT with rs=0xFFFFFFFE (-2), rt=3. busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. hi/lo unchanged while busy.
- DIVU with rs=100, rt=7. After 10 cycles lo=14, hi=2. DIV with rs=-7, rt=2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV with rt=0 and rs=0x1234 gives lo=0xFFFFFFFF, hi=0x1234. DIV 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0.
- MTHI with rs=0xDEADBEEF while idle: hi=0xDEADBEEF next cycle, busy never rises. MTLO issued during a MULT's busy window is ignored.
- reset asserted on the 3rd busy cycle of a DIV: next cycle busy=0, hi=lo=0, no later commit.
- With MDU_FLUSH_EN: MULTU with rs=rt=0xFFFFFFFF, then flush on busy cycle 2. busy=0 next cycle, hi/lo hold their prior values; a new MULTU then completes normally with hi=0xFFFFFFFE, lo=0x00000001.
